// File: rtl/dsp_mult_signed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dsp_mult_signed                                            |
// | Description : Pipelined signed multiplier with carry-in,                 |
// |               p = a*b + carryin. Shaped to map onto a single iCE40       |
// |               SB_MAC16 tile: input registers, multiply, carry add,       |
// |               output register.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk      in   1        single clock, all state on rising edge          |
// |   rst      in   1        asynchronous reset, active-low (0 = reset)      |
// |   a        in   A_WIDTH  signed multiplicand                             |
// |   b        in   B_WIDTH  signed multiplier                               |
// |   carryin  in   1        unsigned +1 added at the result LSB             |
// |   p        out  P_WIDTH  signed result a*b+carryin, registered           |
// | Parameters                                                               |
// |   A_WIDTH, B_WIDTH : operand widths (two's complement)                   |
// |   P_WIDTH          : result width, must be >= A_WIDTH+B_WIDTH            |
// | Build option                                                             |
// |   DSP_MULT_PIPE_EN : when defined, adds a product register between the   |
// |                      multiplier and the carry adder (latency 3 instead   |
// |                      of 2). Results are identical in both builds.        |
// +--------------------------------------------------------------------------+
module dsp_mult_signed #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  input  logic                      carryin,
  output logic signed [P_WIDTH-1:0] p
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  // Stage 1: operand and carry registers
  logic signed [A_WIDTH-1:0] a_d, a_q;
  logic signed [B_WIDTH-1:0] b_d, b_q;
  logic                      c_d, c_q;

  // Multiply datapath (combinational between stage 1 and the next register)
  logic signed [M_WIDTH-1:0] a_ext;
  logic signed [M_WIDTH-1:0] b_ext;
  logic signed [M_WIDTH-1:0] mult_full;
  logic signed [P_WIDTH-1:0] mult_ext;

  // Output register
  logic signed [P_WIDTH-1:0] p_d, p_q;

  // --------------------------------------------------------------------------
  // Stage 1 next-state
  // --------------------------------------------------------------------------
  always_comb begin
    a_d = a;
    b_d = b;
    c_d = carryin;
  end

  // --------------------------------------------------------------------------
  // Full-precision signed product. Both operands are sign-extended to the
  // product width first so the multiply is done entirely at M_WIDTH; the
  // low M_WIDTH bits of that product are exact for any pair of operands.
  // The result is then sign-extended to P_WIDTH (a no-op when equal).
  // --------------------------------------------------------------------------
  always_comb begin
    a_ext                  = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q};
    b_ext                  = {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
    mult_full              = a_ext * b_ext;
    mult_ext               = {P_WIDTH{mult_full[M_WIDTH-1]}};
    mult_ext[M_WIDTH-1:0]  = mult_full;
  end

`ifdef DSP_MULT_PIPE_EN
  // --------------------------------------------------------------------------
  // Pipelined build: product and its carry travel together through an
  // extra register so the carry still lines up with its own product.
  // --------------------------------------------------------------------------
  logic signed [P_WIDTH-1:0] prod_d, prod_q;
  logic                      c2_d, c2_q;
  logic signed [P_WIDTH-1:0] carry_ext;

  always_comb begin
    prod_d = mult_ext;
    c2_d   = c_q;
  end

  always_comb begin
    // carryin is an unsigned +1, so it is zero-extended
    carry_ext = {{(P_WIDTH-1){1'b0}}, c2_q};
    p_d       = prod_q + carry_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      c2_q   <= 1'b0;
    end else begin
      prod_q <= prod_d;
      c2_q   <= c2_d;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Default build: carry add directly after the multiplier.
  // --------------------------------------------------------------------------
  logic signed [P_WIDTH-1:0] carry_ext;

  always_comb begin
    // carryin is an unsigned +1, so it is zero-extended
    carry_ext = {{(P_WIDTH-1){1'b0}}, c_q};
    p_d       = mult_ext + carry_ext;
  end
`endif

  // --------------------------------------------------------------------------
  // Stage 1 and output registers. Reset clears everything asynchronously so
  // p reads 0 immediately and any in-flight operands are discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mult_signed.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dsp_mult_signed                                         |
// | Description : Self-checking bench for dsp_mult_signed. Expected results  |
// |               are pushed to a scoreboard queue at the capturing clock    |
// |               edge and popped once the pipeline latency has elapsed.     |
// |               Honours DSP_MULT_PIPE_EN (latency 3) when defined.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dsp_mult_signed;

`ifdef DSP_MULT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk;
  logic               rst;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               carryin;
  logic signed [31:0] p;

  int checks;
  int errors;

  logic [31:0] sb[$];

  dsp_mult_signed #(
    .A_WIDTH(16),
    .B_WIDTH(16),
    .P_WIDTH(32)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .carryin(carryin),
    .p      (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic signed [15:0] ga,
                                         input logic signed [15:0] gb,
                                         input logic gc);
    int r;
    r = int'(ga) * int'(gb) + (gc ? 1 : 0);
    return r;
  endfunction

  // Drive one set of operands, let one rising edge capture them, and return
  // the value p must hold just after that edge.
  task automatic cycle(input logic signed [15:0] ca, input logic signed [15:0] cb,
                       input logic cc, output logic [31:0] exp_p);
    a       = ca;
    b       = cb;
    carryin = cc;
    @(posedge clk);
    if (rst) sb.push_back(golden(ca, cb, cc));
    else     sb.delete();
    #1;
    if (sb.size() >= LAT) exp_p = sb.pop_front();
    else                  exp_p = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    // Create a real falling edge on rst and check the async clear.
    rst = 1'b1;
    a = 16'sd0; b = 16'sd0; carryin = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (p !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: p=%h expected %h", p, 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(16'($urandom), 16'($urandom), 1'($urandom), e);
      checks++;
      if (p !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: p=%h expected %h", i, p, 32'd0);
      end
    end
    rst = 1'b1;
    // First valid result only after LAT edges; zero before that.
    for (int i = 0; i < LAT + 2; i++) begin
      cycle(16'sd100, -16'sd3, 1'b1, e);
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL reset_release[%0d]: p=%h expected %h", i, p, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] e;
    for (int i = 0; i < 10; i++) begin
      cycle(16'sd38, 16'sd22, 1'b1, e);
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL hold_sb[%0d]: p=%h expected %h", i, p, e);
      end
    end
    checks++;
    if (p !== 32'd837) begin
      errors++;
      $display("FAIL hold_const: p=%h expected %h", p, 32'd837);
    end
  endtask

  task automatic test_zero_then_value();
    logic [31:0] e;
    for (int i = 0; i < LAT + 1; i++) cycle(16'sd0, 16'sd0, 1'b0, e);
    checks++;
    if (p !== 32'd0 || e !== 32'd0) begin
      errors++;
      $display("FAIL zero: p=%h expected %h", p, 32'd0);
    end
    for (int i = 0; i < LAT + 1; i++) begin
      cycle(16'sd33, 16'sd12, 1'b0, e);
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL zero_to_value_sb[%0d]: p=%h expected %h", i, p, e);
      end
    end
    checks++;
    if (p !== 32'd396) begin
      errors++;
      $display("FAIL value_396: p=%h expected %h", p, 32'd396);
    end
  endtask

  task automatic test_signed();
    logic [31:0] e;
    for (int i = 0; i < LAT + 1; i++) cycle(-16'sd5, 16'sd7, 1'b1, e);
    checks++;
    if (p !== 32'hFFFF_FFDE) begin
      errors++;
      $display("FAIL signed_neg: p=%h expected %h", p, 32'hFFFF_FFDE);
    end
    for (int i = 0; i < LAT + 1; i++) cycle(-16'sd32768, -16'sd32768, 1'b1, e);
    checks++;
    if (p !== 32'h4000_0001) begin
      errors++;
      $display("FAIL signed_max: p=%h expected %h", p, 32'h4000_0001);
    end
    // Most negative times most positive, carry must not sign-extend.
    for (int i = 0; i < LAT + 1; i++) cycle(-16'sd32768, 16'sd32767, 1'b1, e);
    checks++;
    if (p !== 32'hC000_8001) begin
      errors++;
      $display("FAIL signed_mixed: p=%h expected %h", p, 32'hC000_8001);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int i = 0; i < 40; i++) begin
      cycle(16'($urandom), 16'($urandom), 1'($urandom), e);
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: p=%h expected %h", i, p, e);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [31:0] e;
    for (int i = 0; i < 5; i++) cycle(16'sd1234, -16'sd4321, 1'b1, e);
    // Pulse rst low between edges; p must clear without a clock.
    #3 rst = 1'b0;
    #1;
    checks++;
    if (p !== 32'd0) begin
      errors++;
      $display("FAIL midstream_async: p=%h expected %h", p, 32'd0);
    end
    sb.delete();
    #1 rst = 1'b1;
    // Any stale in-flight value would show up here instead of 0.
    for (int i = 0; i < LAT + 3; i++) begin
      cycle(16'sd77, 16'sd5, 1'b0, e);
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL midstream_flush[%0d]: p=%h expected %h", i, p, e);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    a       = 16'sd0;
    b       = 16'sd0;
    carryin = 1'b0;
    test_reset();
    test_hold();
    test_zero_then_value();
    test_signed();
    test_back_to_back();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
